// File: rtl/qracc_csr_regfile.sv
// QRAcc CSR register file: bus-facing shadow CSRs, trigger/clear pulse generation
// and the atomically latched active layer configuration for qracc_controller.
package qracc_pkg;

   typedef struct packed {
      logic [31:0] data_in;
      logic [31:0] addr;
      logic        wen;
      logic        valid;
   } bus_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] data_out;
      logic        rd_data_valid;
   } bus_resp_t;

   typedef enum logic [2:0] {
      TRIGGER_IDLE            = 3'd0,
      TRIGGER_COMPUTE_ANALOG  = 3'd1,
      TRIGGER_COMPUTE_DIGITAL = 3'd2,
      TRIGGER_LOAD_ACTIVATION = 3'd3,
      TRIGGER_READ_OUTPUT     = 3'd4,
      TRIGGER_LOAD_WEIGHTS    = 3'd5,
      TRIGGER_RSVD6           = 3'd6,
      TRIGGER_RSVD7           = 3'd7
   } qracc_trigger_t;

   typedef struct packed {
      logic        binary_cfg;              // CSR1[0]
      logic        unsigned_acts;           // CSR1[1]
      logic [3:0]  adc_ref_range_shifts;    // CSR1[7:4]
      logic [3:0]  filter_size_y;           // CSR1[11:8]
      logic [3:0]  filter_size_x;           // CSR1[15:12]
      logic [3:0]  stride_x;                // CSR1[19:16]
      logic [3:0]  stride_y;                // CSR1[23:20]
      logic [3:0]  n_input_bits_cfg;        // CSR1[27:24]
      logic [3:0]  n_output_bits_cfg;       // CSR1[31:28]
      logic [15:0] input_fmap_dimx;         // CSR2[15:0]
      logic [15:0] input_fmap_dimy;         // CSR2[31:16]
      logic [15:0] output_fmap_dimx;        // CSR3[15:0]
      logic [15:0] output_fmap_dimy;        // CSR3[31:16]
      logic [15:0] num_input_channels;      // CSR4[15:0]
      logic [15:0] num_output_channels;     // CSR4[31:16]
      logic [15:0] mapped_matrix_offset_x;  // CSR5[15:0]
      logic [15:0] mapped_matrix_offset_y;  // CSR5[31:16]
      logic [3:0]  padding;                 // CSR6[3:0]
      logic [7:0]  padding_value;           // CSR6[11:4]
      logic        preserve_ifmap;          // CSR0[12]
   } qracc_config_t;

endpackage

module qracc_csr_regfile
   import qracc_pkg::*;
#(
   parameter logic [31:0] CSR_BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_CSRS      = 7
) (
   input  logic           clk,
   input  logic           nrst,
   input  bus_req_t       bus_req_i,
   output bus_resp_t      bus_resp_o,
   output qracc_config_t  cfg_o,
   output qracc_trigger_t trigger_o,
   output logic           clear_o,
   output logic           inst_write_mode_o,
   input  logic           busy_i,
   input  logic [3:0]     ctrl_state_i
);

   localparam logic [31:0] CSR1_RESET = 32'h8811_1100;

   logic           ready_q;
   logic           rd_valid_q;
   logic [31:0]    rd_data_q;
   logic [31:0]    shadow_q [1:6];
   logic           inst_write_mode_q;
   logic           preserve_ifmap_q;
   logic           trig_dropped_q;
   logic           clear_q;
   qracc_trigger_t trigger_q;
   qracc_config_t  cfg_q;

   logic           hit;
   logic           idx_ok;
   logic [2:0]     idx;
   logic           acc;
   logic           wr;
   logic           rd;
   logic           csr0_wr;
   logic [31:0]    wdata;
   logic [31:0]    csr0_view;
   logic [31:0]    rd_mux;
   logic [31:0]    wmask;
   qracc_config_t  cfg_next;
   logic           unused_addr_lsbs;

   assign hit     = (bus_req_i.addr[31:5] == CSR_BASE_ADDR[31:5]);
   assign idx     = bus_req_i.addr[4:2];
   assign idx_ok  = hit && (32'(idx) < NUM_CSRS);
   assign acc     = bus_req_i.valid && ready_q;
   assign wr      = acc && bus_req_i.wen && idx_ok;
   assign rd      = acc && !bus_req_i.wen;
   assign csr0_wr = wr && (idx == 3'd0);
   assign wdata   = bus_req_i.data_in;
   assign unused_addr_lsbs = ^bus_req_i.addr[1:0];

   assign csr0_view = {19'b0, preserve_ifmap_q, ctrl_state_i, trig_dropped_q,
                       1'b0, inst_write_mode_q, busy_i, 4'b0};

   always_comb begin
      rd_mux = '0;
      if (idx_ok) begin
         case (idx)
            3'd0:    rd_mux = csr0_view;
            3'd1:    rd_mux = shadow_q[1];
            3'd2:    rd_mux = shadow_q[2];
            3'd3:    rd_mux = shadow_q[3];
            3'd4:    rd_mux = shadow_q[4];
            3'd5:    rd_mux = shadow_q[5];
            3'd6:    rd_mux = shadow_q[6];
            default: rd_mux = '0;
         endcase
      end
   end

   always_comb begin
      case (idx)
         3'd1:    wmask = 32'hFFFF_FFF3;
         3'd6:    wmask = 32'h0000_0FFF;
         default: wmask = '1;
      endcase
   end

   // Snapshot taken at trigger acceptance; preserve_ifmap comes from the triggering write itself.
   always_comb begin
      cfg_next                        = '0;
      cfg_next.binary_cfg             = shadow_q[1][0];
      cfg_next.unsigned_acts          = shadow_q[1][1];
      cfg_next.adc_ref_range_shifts   = shadow_q[1][7:4];
      cfg_next.filter_size_y          = shadow_q[1][11:8];
      cfg_next.filter_size_x          = shadow_q[1][15:12];
      cfg_next.stride_x               = shadow_q[1][19:16];
      cfg_next.stride_y               = shadow_q[1][23:20];
      cfg_next.n_input_bits_cfg       = shadow_q[1][27:24];
      cfg_next.n_output_bits_cfg      = shadow_q[1][31:28];
      cfg_next.input_fmap_dimx        = shadow_q[2][15:0];
      cfg_next.input_fmap_dimy        = shadow_q[2][31:16];
      cfg_next.output_fmap_dimx       = shadow_q[3][15:0];
      cfg_next.output_fmap_dimy       = shadow_q[3][31:16];
      cfg_next.num_input_channels     = shadow_q[4][15:0];
      cfg_next.num_output_channels    = shadow_q[4][31:16];
      cfg_next.mapped_matrix_offset_x = shadow_q[5][15:0];
      cfg_next.mapped_matrix_offset_y = shadow_q[5][31:16];
      cfg_next.padding                = shadow_q[6][3:0];
      cfg_next.padding_value          = shadow_q[6][11:4];
      cfg_next.preserve_ifmap         = wdata[12];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ready_q           <= 1'b0;
         rd_valid_q        <= 1'b0;
         rd_data_q         <= '0;
         for (int unsigned i = 1; i <= 6; i++)
            shadow_q[i] <= (i == 1) ? CSR1_RESET : '0;
         inst_write_mode_q <= 1'b0;
         preserve_ifmap_q  <= 1'b0;
         trig_dropped_q    <= 1'b0;
         clear_q           <= 1'b0;
         trigger_q         <= TRIGGER_IDLE;
         cfg_q             <= '0;
         cfg_q.stride_x          <= 4'd1;
         cfg_q.stride_y          <= 4'd1;
         cfg_q.filter_size_x     <= 4'd1;
         cfg_q.filter_size_y     <= 4'd1;
         cfg_q.n_input_bits_cfg  <= 4'd8;
         cfg_q.n_output_bits_cfg <= 4'd8;
      end else begin
         ready_q    <= 1'b1;
         rd_valid_q <= rd;
         if (rd)
            rd_data_q <= rd_mux;
         trigger_q <= TRIGGER_IDLE;
         clear_q   <= 1'b0;
         for (int unsigned i = 1; i <= 6; i++)
            if (wr && (idx == 3'(i)))
               shadow_q[i] <= wdata & wmask;
         if (csr0_wr) begin
            inst_write_mode_q <= wdata[5];
            preserve_ifmap_q  <= wdata[12];
            if (wdata[3]) begin
               clear_q        <= 1'b1;
               trig_dropped_q <= 1'b0;
            end else if (wdata[2:0] != 3'd0) begin
               if (busy_i) begin
                  trig_dropped_q <= 1'b1;
               end else begin
                  trigger_q <= qracc_trigger_t'(wdata[2:0]);
                  cfg_q     <= cfg_next;
               end
            end
         end
      end
   end

   always_comb begin
      bus_resp_o               = '0;
      bus_resp_o.ready         = ready_q;
      bus_resp_o.data_out      = rd_data_q;
      bus_resp_o.rd_data_valid = rd_valid_q;
   end

   assign cfg_o             = cfg_q;
   assign trigger_o         = trigger_q;
   assign clear_o           = clear_q;
   assign inst_write_mode_o = inst_write_mode_q;

endmodule

// File: tb/tb_qracc_csr_regfile.sv
// Directed self-checking bench for qracc_csr_regfile with hand-computed expectations.
module tb_qracc_csr_regfile;
   import qracc_pkg::*;

   logic           clk;
   logic           nrst;
   bus_req_t       req;
   bus_resp_t      resp;
   qracc_config_t  cfg;
   qracc_trigger_t trig;
   logic           clr;
   logic           iwm;
   logic           busy;
   logic [3:0]     state;

   int unsigned n_checks;
   int unsigned n_pass;

   qracc_csr_regfile #(
      .CSR_BASE_ADDR (32'h0000_0000),
      .NUM_CSRS      (7)
   ) dut (
      .clk               (clk),
      .nrst              (nrst),
      .bus_req_i         (req),
      .bus_resp_o        (resp),
      .cfg_o             (cfg),
      .trigger_o         (trig),
      .clear_o           (clr),
      .inst_write_mode_o (iwm),
      .busy_i            (busy),
      .ctrl_state_i      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      req.addr    = a;
      req.data_in = d;
      req.wen     = 1'b1;
      req.valid   = 1'b1;
      tick();
      req.valid   = 1'b0;
      req.wen     = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      req.addr    = a;
      req.data_in = '0;
      req.wen     = 1'b0;
      req.valid   = 1'b1;
      tick();
      req.valid   = 1'b0;
      check({tag, "_vld"}, 32'(resp.rd_data_valid), 32'd1);
      check({tag, "_data"}, resp.data_out, exp);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      nrst  = 1'b0;
      req   = '0;
      busy  = 1'b0;
      state = 4'h0;
      #12;
      check("rst_ready", 32'(resp.ready), 32'd0);
      check("rst_rdvld", 32'(resp.rd_data_valid), 32'd0);
      check("rst_dout", resp.data_out, 32'h0);
      check("rst_trig", 32'(trig), 32'd0);
      check("rst_clr", 32'(clr), 32'd0);
      check("rst_iwm", 32'(iwm), 32'd0);
      nrst = 1'b1;
      #1;
      check("rel_ready_lo", 32'(resp.ready), 32'd0);
      tick();
      check("rel_ready_hi", 32'(resp.ready), 32'd1);

      rd_check("csr1_rst", 32'h4, 32'h8811_1100);
      check("cfg_nin_rst", 32'(cfg.n_input_bits_cfg), 32'd8);
      check("cfg_nout_rst", 32'(cfg.n_output_bits_cfg), 32'd8);
      tick();
      check("idle_rdvld", 32'(resp.rd_data_valid), 32'd0);
      check("idle_hold", resp.data_out, 32'h8811_1100);

      do_write(32'h10, 32'h0040_0020);
      check("wr_rdvld", 32'(resp.rd_data_valid), 32'd0);
      do_write(32'h0, 32'h3);
      check("trig3", 32'(trig), 32'd3);
      check("cfg_nic", 32'(cfg.num_input_channels), 32'd32);
      check("cfg_noc", 32'(cfg.num_output_channels), 32'd64);
      tick();
      check("trig3_end", 32'(trig), 32'd0);

      do_write(32'h08, 32'h0010_0010);
      rd_check("csr2", 32'h08, 32'h0010_0010);
      check("dimx_shadow_only", 32'(cfg.input_fmap_dimx), 32'd0);
      do_write(32'h0, 32'h1);
      check("trig1", 32'(trig), 32'd1);
      check("dimx_latched", 32'(cfg.input_fmap_dimx), 32'd16);

      busy  = 1'b1;
      state = 4'h5;
      do_write(32'h0, 32'h4);
      check("trig_busy_drop", 32'(trig), 32'd0);
      check("cfg_kept", 32'(cfg.num_input_channels), 32'd32);
      rd_check("csr0_dropped", 32'h0, 32'h0000_0590);
      do_write(32'h0, 32'h8);
      check("clr_pulse", 32'(clr), 32'd1);
      tick();
      check("clr_end", 32'(clr), 32'd0);
      rd_check("csr0_after_clr", 32'h0, 32'h0000_0510);

      busy  = 1'b0;
      state = 4'h0;
      do_write(32'h0, 32'hB);
      check("clrtrig_clr", 32'(clr), 32'd1);
      check("clrtrig_trig", 32'(trig), 32'd0);
      rd_check("csr0_clrtrig", 32'h0, 32'h0);

      do_write(32'h0, 32'h2);
      check("b2b_first", 32'(trig), 32'd2);
      busy = 1'b1;
      do_write(32'h0, 32'h5);
      check("b2b_second", 32'(trig), 32'd0);
      busy = 1'b0;
      rd_check("csr0_b2b", 32'h0, 32'h0000_0080);

      do_write(32'h0, 32'h0000_1020);
      check("iwm_set", 32'(iwm), 32'd1);
      check("pres_not_latched", 32'(cfg.preserve_ifmap), 32'd0);
      rd_check("csr0_iwm", 32'h0, 32'h0000_10A0);
      do_write(32'h0, 32'h0000_1001);
      check("trig_pres", 32'(trig), 32'd1);
      check("pres_latched", 32'(cfg.preserve_ifmap), 32'd1);
      check("iwm_clr", 32'(iwm), 32'd0);

      do_write(32'h04, 32'hFFFF_FFFF);
      rd_check("csr1_mask", 32'h04, 32'hFFFF_FFF3);
      do_write(32'h18, 32'hFFFF_FFFF);
      rd_check("csr6_mask", 32'h18, 32'h0000_0FFF);
      rd_check("byte_off", 32'h07, 32'hFFFF_FFF3);
      do_write(32'h24, 32'h0);
      rd_check("miss_wr_ignored", 32'h04, 32'hFFFF_FFF3);
      rd_check("idx7", 32'h1C, 32'h0);
      rd_check("out_window", 32'h104, 32'h0);
      do_write(32'h0, 32'h1);
      check("cfg_pad_val", 32'(cfg.padding_value), 32'd255);
      check("cfg_stride_x", 32'(cfg.stride_x), 32'd15);

      req.addr  = 32'h04;
      req.wen   = 1'b0;
      req.valid = 1'b1;
      #3;
      nrst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(resp.ready), 32'd0);
      check("mid_rst_iwm_cfg", 32'(cfg.n_input_bits_cfg), 32'd8);
      tick();
      req.valid = 1'b0;
      check("mid_rst_rdvld", 32'(resp.rd_data_valid), 32'd0);
      check("mid_rst_dout", resp.data_out, 32'h0);
      check("mid_rst_nic", 32'(cfg.num_input_channels), 32'd0);
      #2;
      nrst = 1'b1;
      #1;
      check("rel2_ready_lo", 32'(resp.ready), 32'd0);
      tick();
      check("rel2_ready_hi", 32'(resp.ready), 32'd1);
      rd_check("csr1_rst2", 32'h04, 32'h8811_1100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
